// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: CPU memory-mapped I/O front end for a byte UART.
//   Decodes loads/stores in the IO_NIB region (io_addr[31:28]) on io_addr[7:2],
//   holds one outgoing TX byte, buffers received RX bytes and runs a free-running
//   32-bit cycle counter.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   io_addr/io_wdata    CPU byte address / store data (only [7:0] used)
//   io_we/io_re         one-cycle store/load strobes
//   io_rdata            registered load data, valid the cycle after io_re
//   tx_data/tx_valid    outgoing byte handshake (tx_ready from transmitter)
//   rx_data/rx_valid    incoming byte handshake (rx_ready back to receiver)
// Configuration:
//   UART_RX_FIFO_EN defined   -> RX buffer is an RX_DEPTH-entry FIFO
//   UART_RX_FIFO_EN undefined -> RX buffer is a single holding register
// Register map (word offsets): 0x00 status, 0x04 rx status, 0x08 tx, 0x0C rx data,
//   0x10 cycle counter.
module uart_mmio_ctrl #(
  parameter int unsigned RX_DEPTH = 4,
  parameter logic [3:0]  IO_NIB   = 4'h8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_we,
  input  logic        io_re,
  output logic [31:0] io_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam logic [5:0] A_STAT = 6'h00;
  localparam logic [5:0] A_RXST = 6'h01;
  localparam logic [5:0] A_TX   = 6'h02;
  localparam logic [5:0] A_RXD  = 6'h03;
  localparam logic [5:0] A_CNT  = 6'h04;

  logic [31:0] r_rdata;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic        r_tx_ovf;
  logic [31:0] r_cnt;

  logic        w_sel;
  logic [5:0]  w_off;
  logic        w_rd;
  logic        w_wr;
  logic        w_rx_full;
  logic        w_rx_empty;
  logic [7:0]  w_rx_head;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Address decode; byte lane bits [1:0] are ignored.
  assign w_sel = (io_addr[31:28] == IO_NIB);
  assign w_off = io_addr[7:2];
  assign w_rd  = io_re & w_sel;
  assign w_wr  = io_we & w_sel;

  assign w_push   = rx_valid & ~w_rx_full;
  assign w_pop    = w_rd & (w_off == A_RXD) & ~w_rx_empty;
  assign rx_ready = ~w_rx_full;

`ifdef UART_RX_FIFO_EN
  localparam int unsigned PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

  logic [7:0]    r_mem [RX_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;

  assign w_rx_full  = (r_count == (PW+1)'(RX_DEPTH));
  assign w_rx_empty = (r_count == '0);
  assign w_rx_head  = r_mem[r_rptr];
  assign w_unused   = ^{io_addr[27:8], io_addr[1:0], io_wdata[31:8]};

  // Storage needs no reset: occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= rx_data;
  end

  // Pointers wrap naturally because RX_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
`else
  logic [7:0] r_rx_hold;
  logic       r_rx_full;

  assign w_rx_full  = r_rx_full;
  assign w_rx_empty = ~r_rx_full;
  assign w_rx_head  = r_rx_hold;
  assign w_unused   = ^{io_addr[27:8], io_addr[1:0], io_wdata[31:8], 32'(RX_DEPTH)};

  // Single-entry buffer: push only when empty, pop only when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_hold <= '0;
      r_rx_full <= 1'b0;
    end else if (w_push) begin
      r_rx_hold <= rx_data;
      r_rx_full <= 1'b1;
    end else if (w_pop) begin
      r_rx_full <= 1'b0;
    end
  end
`endif

  // TX holding register; overflow set takes priority over the status-read clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_ovf   <= 1'b0;
    end else begin
      if (w_wr && (w_off == A_TX)) begin
        if (!r_tx_valid || tx_ready) begin
          r_tx_data  <= io_wdata[7:0];
          r_tx_valid <= 1'b1;
        end
      end else if (r_tx_valid && tx_ready) begin
        r_tx_valid <= 1'b0;
      end
      if (w_wr && (w_off == A_TX) && r_tx_valid && !tx_ready) r_tx_ovf <= 1'b1;
      else if (w_rd && (w_off == A_STAT))                     r_tx_ovf <= 1'b0;
    end
  end

  // Free-running cycle counter; any write to its offset restarts it at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_cnt <= '0;
    else if (w_wr && (w_off == A_CNT)) r_cnt <= '0;
    else                               r_cnt <= r_cnt + 32'd1;
  end

  // Read mux from pre-edge state.
  always_comb begin
    w_rdata = '0;
    case (w_off)
      A_STAT:  w_rdata = {30'b0, r_tx_ovf, ~r_tx_valid};
      A_RXST:  w_rdata = {31'b0, ~w_rx_empty};
      A_RXD:   w_rdata = w_rx_empty ? 32'd0 : {24'b0, w_rx_head};
      A_CNT:   w_rdata = r_cnt;
      default: w_rdata = '0;
    endcase
  end

  // Unselected reads leave the load data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (w_rd) r_rdata <= w_rdata;
  end

  assign io_rdata = r_rdata;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
module tb_uart_mmio_ctrl;

`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_we;
  logic        io_re;
  logic [31:0] io_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  uart_mmio_ctrl #(.RX_DEPTH(4), .IO_NIB(4'h8)) dut (
    .clk(clk), .rst_n(rst_n),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we), .io_re(io_re),
    .io_rdata(io_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  // Scoreboard: every load issued pushes its expected data; compared one cycle later.
  always begin
    @(posedge clk);
    if (io_re) begin
      #1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow: io_rdata=%h with no expected entry", io_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (io_rdata !== mon_exp) begin
          bad++;
          $display("FAIL rdata: io_rdata=%h expected %h", io_rdata, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    io_addr = a;
    io_re   = 1'b1;
    exp_q.push_back(e);
    tick();
    io_re = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_addr  = a;
    io_wdata = d;
    io_we    = 1'b1;
    tick();
    io_we = 1'b0;
  endtask

  task automatic push_rx(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; io_addr = '0; io_wdata = '0; io_we = 1'b0; io_re = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    #22;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready: got %b expected 1", rx_ready); end
    total++; if (io_rdata !== 32'h0) begin bad++; $display("FAIL reset_io_rdata: got %h expected 0", io_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd(32'h8000_0000, 32'h1);
    rd(32'h8000_0004, 32'h0);
  endtask

  task automatic test_tx();
    tx_ready = 1'b0;
    wr(32'h8000_0008, 32'h0000_0041);
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL tx_load_valid: got %b expected 1", tx_valid); end
    total++; if (tx_data !== 8'h41) begin bad++; $display("FAIL tx_load_data: got %h expected 41", tx_data); end
    wr(32'h8000_0008, 32'hFFFF_FF42);
    total++; if (tx_data !== 8'h41) begin bad++; $display("FAIL tx_hold_data: got %h expected 41", tx_data); end
    rd(32'h8000_0000, 32'h2);
    rd(32'h8000_0000, 32'h0);
    // Accept a new byte in the same cycle the old one hands off.
    tx_ready = 1'b1;
    wr(32'h8000_0008, 32'h0000_0043);
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL tx_replace_valid: got %b expected 1", tx_valid); end
    total++; if (tx_data !== 8'h43) begin bad++; $display("FAIL tx_replace_data: got %h expected 43", tx_data); end
    tick();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_drain_valid: got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
    rd(32'h8000_0000, 32'h1);
  endtask

  task automatic test_rx_fifo();
    for (int i = 0; i < DEPTH; i++) begin
      total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rx_fill_ready_%0d: got %b expected 1", i, rx_ready); end
      push_rx(8'(8'h10 + i));
    end
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL rx_full_ready: got %b expected 0", rx_ready); end
    push_rx(8'hEE);
    for (int i = 0; i < DEPTH; i++) rd(32'h8000_000C, 32'(8'h10 + i));
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rx_drained_ready: got %b expected 1", rx_ready); end
    rd(32'h8000_000C, 32'h0);
    rd(32'h8000_0004, 32'h0);
  endtask

  task automatic test_push_pop();
    push_rx(8'hAA);
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    rd(32'h8000_000C, 32'h0000_00AA);
    rx_valid = 1'b0;
    rd(32'h8000_0004, (DEPTH > 1) ? 32'h1 : 32'h0);
    rd(32'h8000_000C, (DEPTH > 1) ? 32'h55 : 32'h0);
  endtask

  task automatic test_decode();
    push_rx(8'h77);
    rd(32'h8000_0004, 32'h1);
    rd(32'h0000_000C, 32'h1);
    rd(32'h8000_0014, 32'h0);
    rd(32'h8000_000C, 32'h77);
    rd(32'h8000_0004, 32'h0);
  endtask

  task automatic test_counter();
    wr(32'h8000_0010, 32'h0);
    tick();
    tick();
    rd(32'h8000_0010, 32'h2);
    wr(32'h8000_0010, 32'h0);
    // Load and store together: load sees pre-edge count, store clears again.
    io_we = 1'b1;
    rd(32'h8000_0010, 32'h0);
    io_we = 1'b0;
    rd(32'h8000_0010, 32'h0);
    // Wrap boundary.
    io_addr = 32'h8000_0010;
    io_re   = 1'b1;
    force dut.r_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_cnt;
    exp_q.push_back(32'hFFFF_FFFF);
    tick();
    exp_q.push_back(32'h0);
    tick();
    io_re = 1'b0;
  endtask

  task automatic test_async_reset();
    tx_ready = 1'b0;
    wr(32'h8000_0008, 32'h5A);
    push_rx(8'h21);
    push_rx(8'h22);
    rd(32'h8000_0004, 32'h1);
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_tx_valid: got %b expected 1", tx_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL areset_tx_valid: got %b expected 0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL areset_tx_data: got %h expected 00", tx_data); end
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL areset_rx_ready: got %b expected 1", rx_ready); end
    total++; if (io_rdata !== 32'h0) begin bad++; $display("FAIL areset_io_rdata: got %h expected 0", io_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd(32'h8000_0004, 32'h0);
    rd(32'h8000_0000, 32'h1);
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx_fifo();
    test_push_pop();
    test_decode();
    test_counter();
    test_async_reset();
    tick();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: %0d entries remaining expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

endmodule
